xc_malu_divrem_param: RTL and testbench
=======================================

Name: xc_malu_divrem_param

Overview:
Parametrised iterative restoring divider for div/divu/rem/remu. It is the successor to the fixed 32-bit, 1-bit-per-cycle MALU divider. It adds configurable width and radix, an internal subtractor, RISC-V-correct sign fix-up and corner-case results, and a request/response handshake. It sits beside the MALU multiplier and is driven by the MALU issue logic.

Parameters:
XLEN, 32, operand/result width; must be a multiple of BITS_PER_CYCLE; legal values 8..64.
BITS_PER_CYCLE, 1, quotient bits retired per RUN cycle; legal values 1, 2, 4. N = XLEN/BITS_PER_CYCLE.

Ports:
clock  in  1  core clock; all flops rise-edge.
resetn  in  1  asynchronous active-low reset.
flush  in  1  synchronous abort; returns the block to IDLE.
req_valid  in  1  request present; rs1/rs2/op_* are valid with it.
req_ready  out  1  high in IDLE only; a request is accepted when req_valid && req_ready.
op_signed  in  1  1 = div/rem, 0 = divu/remu.
op_rem  in  1  1 = return remainder, 0 = return quotient.
rs1  in  XLEN  dividend.
rs2  in  XLEN  divisor.
rsp_valid  out  1  result valid; held until acknowledged.
rsp_ack  in  1  consumer takes the result; sampled only while rsp_valid is high.
result  out  XLEN  quotient or remainder; registered.
busy  out  1  high in RUN or FIX.

Behaviour:
- Reset (async, resetn=0): state=IDLE, req_ready=1, rsp_valid=0, busy=0, result=0, all internal registers 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE, on accept:
  - Latch |rs1| and |rs2|. Magnitude is two's-complement negation when op_signed and MSB=1.
  - Latch sign_q = op_signed & (rs1[MSB]^rs2[MSB]) & (rs2!=0), sign_r = op_signed & rs1[MSB], op_rem, and div_zero = (rs2==0).
  - Clear quotient and partial remainder; count=0; go to RUN.
- RUN, each cycle:
  - Retire BITS_PER_CYCLE quotient bits MSB-first with chained restoring steps.
  - Each step: shift the partial remainder left by 1 and bring in the next dividend bit. Compare against the divisor with an (XLEN+1)-bit subtract. If there is no borrow, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - count increments; at count==N-1 go to FIX.
- FIX (1 cycle):
  - result = op_rem ? (sign_r ? -rem : rem) : (sign_q ? -quo : quo). Negation is modulo 2^XLEN.
  - Go to DONE.
- DONE: rsp_valid=1, result stable. rsp_ack=1 causes a transition to IDLE on the same edge. req_ready goes high the following cycle, so there is no back-to-back accept in DONE.
- Latency: accept on edge k; rsp_valid is high after edge k+N+1. For XLEN=32 and BITS_PER_CYCLE=1 this is 33 edges.
- Corner cases (RISC-V M), produced naturally by the datapath plus the sign_q masking:
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): quotient = rs1; remainder = 0.
- flush: from any state, next state is IDLE and rsp_valid drops on the next edge; result keeps its last value. flush has priority over rsp_ack and over a simultaneous accept; no request is accepted in a flush cycle.
- Inputs rs1, rs2 and op_* are only sampled at accept. Changes during RUN have no effect.
- rsp_ack outside DONE is ignored.

Optional Feature:
XC_DIVREM_ZERO_BYPASS_EN
- Defined: at accept, if div_zero, or op_signed with rs1 = -2^(XLEN-1) and rs2 = all ones, go IDLE->FIX directly. FIX loads the corner-case result. rsp_valid is high after edge k+2.
- Undefined: these cases run the full N iterations. The result is bit-identical; only latency differs.

Test Plan:
- divu, XLEN=32, BPC=1: rs1=100, rs2=7 -> result=14 after exactly 33 edges; with op_rem=1 -> 2.
- div signed: rs1=-100 (0xFFFFFF9C), rs2=7 -> quotient 0xFFFFFFF2 (-14); rem -> 0xFFFFFFFE (-2).
- Divide by zero, signed: rs1=0x80000005, rs2=0 -> quotient 0xFFFFFFFF, rem 0x80000005. Latency is 33 edges, or 2 edges with XC_DIVREM_ZERO_BYPASS_EN.
- Overflow: rs1=0x80000000, rs2=0xFFFFFFFF, signed -> quotient 0x80000000, rem 0.
- Handshake and abort:
  - Hold rsp_ack=0 for 10 cycles -> rsp_valid and result stay stable; after ack, req_ready=1 next cycle.
  - Assert flush at RUN count 5 -> IDLE next edge, no rsp_valid.
  - Deassert resetn mid-RUN -> all outputs at reset values immediately, without waiting for a clock edge.
- Parametric: XLEN=64, BPC=4, 10,000 random signed/unsigned pairs vs. reference model -> all match; latency 17 edges.

Source files
------------

// File: rtl/xc_malu_divrem_param_if.sv
// Request/response bundle between the MALU issue logic (master) and the
// parametrised divider (slave).
interface xc_malu_divrem_param_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            op_signed;
    logic            op_rem;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            rsp_valid;
    logic            rsp_ack;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output req_valid, op_signed, op_rem, rs1, rs2, rsp_ack,
        input  req_ready, rsp_valid, result, busy
    );

    modport slave (
        input  req_valid, op_signed, op_rem, rs1, rs2, rsp_ack,
        output req_ready, rsp_valid, result, busy
    );
endinterface

// File: rtl/xc_malu_divrem_param.sv
// Iterative restoring divider (div/divu/rem/remu), BITS_PER_CYCLE quotient bits per cycle.
// Optional XC_DIVREM_ZERO_BYPASS_EN: divide-by-zero and signed overflow skip the iterations.
module xc_malu_divrem_param #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        flush,
    xc_malu_divrem_param_if.slave       bus
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_reg,    state_next;
    logic [XLEN-1:0] dvd_reg,      dvd_next;
    logic [XLEN-1:0] dsr_reg,      dsr_next;
    logic [XLEN-1:0] rem_reg,      rem_next;
    logic [XLEN-1:0] quo_reg,      quo_next;
    logic [CW-1:0]   count_reg,    count_next;
    logic            sign_q_reg,   sign_q_next;
    logic            sign_r_reg,   sign_r_next;
    logic            op_rem_reg,   op_rem_next;
    logic            div_zero_reg, div_zero_next;
    logic [XLEN-1:0] result_reg,   result_next;
`ifdef XC_DIVREM_ZERO_BYPASS_EN
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    logic            bypass_reg,   bypass_next;
    logic            bypass_in;
`endif

    // Operand conditioning at accept time
    logic            accept;
    logic            rs1_neg, rs2_neg;
    logic [XLEN-1:0] abs1, abs2;
    logic            div_zero_in;
    logic [XLEN-1:0] quo_sel;

    assign accept      = bus.req_valid && (state_reg == S_IDLE) && !flush;
    assign rs1_neg     = bus.op_signed & bus.rs1[XLEN-1];
    assign rs2_neg     = bus.op_signed & bus.rs2[XLEN-1];
    assign abs1        = rs1_neg ? -bus.rs1 : bus.rs1;
    assign abs2        = rs2_neg ? -bus.rs2 : bus.rs2;
    assign div_zero_in = (bus.rs2 == '0);
`ifdef XC_DIVREM_ZERO_BYPASS_EN
    assign bypass_in   = div_zero_in ||
                         (bus.op_signed && (bus.rs1 == SMIN) && (bus.rs2 == '1));
`endif

    // Chained restoring steps; step 0 retires the most significant bit of the group
    logic [XLEN-1:0]           rem_c [BITS_PER_CYCLE+1];
    logic [XLEN-1:0]           dvd_c [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] qbits;

    assign rem_c[0] = rem_reg;
    assign dvd_c[0] = dvd_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            logic [XLEN:0]   shifted;
            logic [XLEN+1:0] sub;
            logic            unused_sub;

            assign shifted = {rem_c[gi], dvd_c[gi][XLEN-1]};
            // Top bit of sub is the borrow of the (XLEN+1)-bit subtract
            assign sub     = {1'b0, shifted} - {2'b00, dsr_reg};
            assign qbits[BITS_PER_CYCLE-1-gi] = ~sub[XLEN+1];
            assign rem_c[gi+1] = sub[XLEN+1] ? shifted[XLEN-1:0] : sub[XLEN-1:0];
            assign dvd_c[gi+1] = {dvd_c[gi][XLEN-2:0], 1'b0};
            // Bit XLEN of a non-borrowing difference is always zero (rem < divisor)
            assign unused_sub  = sub[XLEN];
        end
    endgenerate

    // Division by zero yields an all-ones quotient; sign_q is masked off for it
    assign quo_sel = div_zero_reg ? '1 : quo_reg;

    always_comb begin
        state_next    = state_reg;
        dvd_next      = dvd_reg;
        dsr_next      = dsr_reg;
        rem_next      = rem_reg;
        quo_next      = quo_reg;
        count_next    = count_reg;
        sign_q_next   = sign_q_reg;
        sign_r_next   = sign_r_reg;
        op_rem_next   = op_rem_reg;
        div_zero_next = div_zero_reg;
        result_next   = result_reg;
`ifdef XC_DIVREM_ZERO_BYPASS_EN
        bypass_next   = bypass_reg;
`endif

        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        dvd_next      = abs1;
                        dsr_next      = abs2;
                        rem_next      = '0;
                        quo_next      = '0;
                        count_next    = '0;
                        sign_q_next   = bus.op_signed & (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]) & ~div_zero_in;
                        sign_r_next   = rs1_neg;
                        op_rem_next   = bus.op_rem;
                        div_zero_next = div_zero_in;
                        state_next    = S_RUN;
`ifdef XC_DIVREM_ZERO_BYPASS_EN
                        bypass_next   = bypass_in;
                        if (bypass_in) begin
                            state_next = S_FIX;
                        end
`endif
                    end
                end

                S_RUN: begin
                    rem_next   = rem_c[BITS_PER_CYCLE];
                    dvd_next   = dvd_c[BITS_PER_CYCLE];
                    quo_next   = {quo_reg[XLEN-BITS_PER_CYCLE-1:0], qbits};
                    count_next = count_reg + CW'(1);
                    if (count_reg == CW'(N - 1)) begin
                        state_next = S_FIX;
                    end
                end

                S_FIX: begin
`ifdef XC_DIVREM_ZERO_BYPASS_EN
                    if (bypass_reg) begin
                        // First FIX cycle of a bypass: dvd_reg still holds |rs1|
                        quo_next    = div_zero_reg ? '1 : dvd_reg;
                        rem_next    = div_zero_reg ? dvd_reg : '0;
                        bypass_next = 1'b0;
                    end else begin
                        result_next = op_rem_reg ? (sign_r_reg ? -rem_reg : rem_reg)
                                                 : (sign_q_reg ? -quo_sel : quo_sel);
                        state_next  = S_DONE;
                    end
`else
                    result_next = op_rem_reg ? (sign_r_reg ? -rem_reg : rem_reg)
                                             : (sign_q_reg ? -quo_sel : quo_sel);
                    state_next  = S_DONE;
`endif
                end

                S_DONE: begin
                    if (bus.rsp_ack) begin
                        state_next = S_IDLE;
                    end
                end

                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_IDLE;
            dvd_reg      <= '0;
            dsr_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            count_reg    <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            op_rem_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            result_reg   <= '0;
`ifdef XC_DIVREM_ZERO_BYPASS_EN
            bypass_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            dvd_reg      <= dvd_next;
            dsr_reg      <= dsr_next;
            rem_reg      <= rem_next;
            quo_reg      <= quo_next;
            count_reg    <= count_next;
            sign_q_reg   <= sign_q_next;
            sign_r_reg   <= sign_r_next;
            op_rem_reg   <= op_rem_next;
            div_zero_reg <= div_zero_next;
            result_reg   <= result_next;
`ifdef XC_DIVREM_ZERO_BYPASS_EN
            bypass_reg   <= bypass_next;
`endif
        end
    end

    assign bus.req_ready = (state_reg == S_IDLE);
    assign bus.rsp_valid = (state_reg == S_DONE);
    assign bus.busy      = (state_reg == S_RUN) || (state_reg == S_FIX);
    assign bus.result    = result_reg;
endmodule

// File: tb/tb_xc_malu_divrem_param.sv
// Directed bench for xc_malu_divrem_param: a 32-bit/radix-2 instance and a
// 64-bit/4-bits-per-cycle instance share clock, reset and flush.
module tb_xc_malu_divrem_param;
`ifdef XC_DIVREM_ZERO_BYPASS_EN
    localparam int ZL32 = 2;
    localparam int ZL64 = 2;
`else
    localparam int ZL32 = 33;
    localparam int ZL64 = 17;
`endif

    logic clock = 1'b0;
    logic resetn;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    xc_malu_divrem_param_if #(.XLEN(32)) b32 ();
    xc_malu_divrem_param_if #(.XLEN(64)) b64 ();

    xc_malu_divrem_param #(.XLEN(32), .BITS_PER_CYCLE(1)) dut32 (
        .clock (clock),
        .resetn(resetn),
        .flush (flush),
        .bus   (b32)
    );

    xc_malu_divrem_param #(.XLEN(64), .BITS_PER_CYCLE(4)) dut64 (
        .clock (clock),
        .resetn(resetn),
        .flush (flush),
        .bus   (b64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue32(input logic s, input logic r, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        chk("ready32", 64'(b32.req_ready), 64'd1);
        b32.req_valid = 1'b1; b32.op_signed = s; b32.op_rem = r; b32.rs1 = a; b32.rs2 = d;
        @(posedge clock); #1;
        // Scramble operands after accept: they must not be resampled
        b32.req_valid = 1'b0; b32.op_signed = ~s; b32.op_rem = ~r;
        b32.rs1 = 32'hDEADBEEF; b32.rs2 = 32'h00001234;
    endtask

    task automatic issue64(input logic s, input logic r, input logic [63:0] a, input logic [63:0] d);
        @(negedge clock);
        chk("ready64", 64'(b64.req_ready), 64'd1);
        b64.req_valid = 1'b1; b64.op_signed = s; b64.op_rem = r; b64.rs1 = a; b64.rs2 = d;
        @(posedge clock); #1;
        b64.req_valid = 1'b0; b64.op_signed = ~s; b64.op_rem = ~r;
        b64.rs1 = 64'hDEADBEEF_CAFEF00D; b64.rs2 = 64'd3;
    endtask

    task automatic wait32(output int lat);
        lat = 0;
        while (b32.rsp_valid !== 1'b1 && lat < 100) begin
            @(posedge clock); #1; lat++;
        end
    endtask

    task automatic wait64(output int lat);
        lat = 0;
        while (b64.rsp_valid !== 1'b1 && lat < 100) begin
            @(posedge clock); #1; lat++;
        end
    endtask

    task automatic ack32();
        @(negedge clock); b32.rsp_ack = 1'b1;
        @(posedge clock); #1; b32.rsp_ack = 1'b0;
        chk("ack32_valid", 64'(b32.rsp_valid), 64'd0);
        chk("ack32_ready", 64'(b32.req_ready), 64'd1);
    endtask

    task automatic ack64();
        @(negedge clock); b64.rsp_ack = 1'b1;
        @(posedge clock); #1; b64.rsp_ack = 1'b0;
        chk("ack64_valid", 64'(b64.rsp_valid), 64'd0);
    endtask

    task automatic op32(input string tag, input logic s, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue32(s, r, a, d);
        wait32(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk(tag, 64'(b32.result), 64'(exp));
        $display("op32 %s rs1=%h rs2=%h result=%h latency=%0d", tag, a, d, b32.result, lat);
        ack32();
    endtask

    task automatic op64(input string tag, input logic s, input logic r, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] exp, input int exp_lat);
        int lat;
        issue64(s, r, a, d);
        wait64(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk(tag, b64.result, exp);
        $display("op64 %s rs1=%h rs2=%h result=%h latency=%0d", tag, a, d, b64.result, lat);
        ack64();
    endtask

    initial begin
        int lat;
        int stable;
        int seen;
        logic [31:0] held;

        resetn = 1'b0; flush = 1'b0;
        b32.req_valid = 0; b32.op_signed = 0; b32.op_rem = 0; b32.rs1 = 0; b32.rs2 = 0; b32.rsp_ack = 0;
        b64.req_valid = 0; b64.op_signed = 0; b64.op_rem = 0; b64.rs1 = 0; b64.rs2 = 0; b64.rsp_ack = 0;
        #12;
        chk("rst_ready", 64'(b32.req_ready), 64'd1);
        chk("rst_valid", 64'(b32.rsp_valid), 64'd0);
        chk("rst_busy",  64'(b32.busy), 64'd0);
        chk("rst_result", 64'(b32.result), 64'd0);
        chk("rst_result64", b64.result, 64'd0);
        @(negedge clock); resetn = 1'b1;

        op32("divu",     1'b0, 1'b0, 32'd100,      32'd7,        32'd14,       33);
        op32("remu",     1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        33);
        op32("div_neg",  1'b1, 1'b0, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33);
        op32("rem_neg",  1'b1, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33);
        op32("div_nd",   1'b1, 1'b0, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33);
        op32("rem_nd",   1'b1, 1'b1, 32'd100,      32'hFFFFFFF9, 32'd2,        33);
        op32("div_zero", 1'b1, 1'b0, 32'h80000005, 32'd0,        32'hFFFFFFFF, ZL32);
        op32("rem_zero", 1'b1, 1'b1, 32'h80000005, 32'd0,        32'h80000005, ZL32);
        op32("div_ovf",  1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, ZL32);
        op32("rem_ovf",  1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        ZL32);
        op32("divu_big", 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);

        // Withheld acknowledge: response must stay put
        issue32(1'b0, 1'b0, 32'd1000, 32'd10);
        wait32(lat);
        chk("hold_lat", 64'(lat), 64'd33);
        held = b32.result;
        chk("hold_result", 64'(held), 64'd100);
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (b32.rsp_valid !== 1'b1 || b32.result !== held) stable = 0;
        end
        chk("hold_stable", 64'(stable), 64'd1);
        $display("hold result=%h stable=%0d", held, stable);
        ack32();

        // Abort at RUN count 5
        issue32(1'b0, 1'b0, 32'd77, 32'd3);
        repeat (5) @(posedge clock);
        @(negedge clock); flush = 1'b1;
        @(posedge clock); #1; flush = 1'b0;
        chk("flush_busy",   64'(b32.busy), 64'd0);
        chk("flush_ready",  64'(b32.req_ready), 64'd1);
        chk("flush_result", 64'(b32.result), 64'd100);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (b32.rsp_valid === 1'b1) seen = 1;
        end
        chk("flush_novalid", 64'(seen), 64'd0);
        $display("flush busy=%0d ready=%0d late_valid=%0d", b32.busy, b32.req_ready, seen);

        // Asynchronous reset in the middle of RUN
        issue32(1'b1, 1'b0, 32'd500, 32'd9);
        repeat (3) @(posedge clock);
        #3; resetn = 1'b0;
        #1;
        chk("arst_busy",   64'(b32.busy), 64'd0);
        chk("arst_ready",  64'(b32.req_ready), 64'd1);
        chk("arst_valid",  64'(b32.rsp_valid), 64'd0);
        chk("arst_result", 64'(b32.result), 64'd0);
        $display("async reset busy=%0d result=%h", b32.busy, b32.result);
        @(negedge clock); resetn = 1'b1;

        op32("after_rst", 1'b0, 1'b0, 32'd55, 32'd5, 32'd11, 33);

        op64("divu64",  1'b0, 1'b0, 64'h0000000100000000, 64'h10, 64'h0000000010000000, 17);
        op64("div64n",  1'b1, 1'b0, 64'hFFFFFFFFFFFFFC18, 64'd7,  64'hFFFFFFFFFFFFFF72, 17);
        op64("rem64n",  1'b1, 1'b1, 64'hFFFFFFFFFFFFFC18, 64'd7,  64'hFFFFFFFFFFFFFFFA, 17);
        op64("divu64m", 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd10, 64'h1999999999999999, 17);
        op64("remu64m", 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd10, 64'd5,                17);
        op64("divu64_3",1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd3,  64'h5555555555555555, 17);
        op64("ovf64",   1'b1, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, ZL64);
        op64("remu64z", 1'b0, 1'b1, 64'd5, 64'd0, 64'd5, ZL64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
